// File: rtl/raytrace_fixed_pkg.sv
// Shared fixed-point types, saturation constants and FSM states for the ray tracer.
// Used by ray_plane_t and the sequential divider datapath.
package raytrace_fixed_pkg;

  localparam int DEFAULT_Q_BITS = 10;

  typedef logic signed [31:0] fixed_t;

  localparam fixed_t T_SAT_POS = 32'sh7FFF_FFFF;
  localparam fixed_t T_SAT_NEG = 32'sh8000_0001;

  typedef enum logic [1:0] {IDLE, DIV, WRITE} state_t;

  // Two's-complement magnitude; the most negative value maps to 0x80000000 unsigned.
  function automatic logic [31:0] fixed_abs(input fixed_t x);
    logic [31:0] ux;
    ux = x;
    return x[31] ? (~ux + 32'd1) : ux;
  endfunction

endpackage

// File: rtl/udiv_seq.sv
// Unsigned restoring divider producing one quotient bit per cycle, MSB first.
// done, quotient and remainder reflect the step being taken in the final busy cycle.
module udiv_seq #(
  parameter int DIVIDEND_W = 42,
  parameter int DIVISOR_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W:0]    remainder
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W:0]    rem_q;
  logic [DIVISOR_W-1:0]  dsr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    rem_next;
  logic                  qbit;

  // rem_q's top bit acts as the carry out of the shift, so a set carry always subtracts.
  always_comb begin
    trial    = {rem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
    qbit     = rem_q[DIVISOR_W] || (trial >= {1'b0, dsr_q});
    rem_next = qbit ? (trial - {1'b0, dsr_q}) : trial;
  end

  assign done      = busy && (cnt_q == '0);
  assign quotient  = {quo_q[DIVIDEND_W-2:0], qbit};
  assign remainder = rem_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dvd_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start && !busy) begin
      dvd_q <= dividend;
      dsr_q <= divisor;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= CNT_W'(DIVIDEND_W - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
      quo_q <= quotient;
      rem_q <= rem_next;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ray_plane_t.sv
// Ray/plane parameter t = num / den in signed Q fixed point, with a forward-hit flag.
// Define RAY_T_ROUND_EN to round half away from zero instead of truncating.
module ray_plane_t
  import raytrace_fixed_pkg::*;
#(
  parameter int Q_BITS = DEFAULT_Q_BITS,
  parameter int T_MIN  = 1
) (
  input  logic   clock,
  input  logic   reset,
  input  fixed_t num,
  input  logic   num_empty,
  output logic   num_rd_en,
  input  fixed_t den,
  input  logic   den_empty,
  output logic   den_rd_en,
  output fixed_t out_t,
  output logic   out_hit,
  input  logic   out_full,
  output logic   out_wr_en
);

  localparam int DVD_W = 32 + Q_BITS;

  state_t            state;
  logic              sign_q;
  logic [31:0]       den_mag_q;

  logic              pop;
  logic [31:0]       num_mag;
  logic [31:0]       den_mag;
  logic              div_start;
  logic [DVD_W-1:0]  div_dividend;
  logic              div_busy;
  logic              div_done;
  logic [DVD_W-1:0]  div_quo;
  logic [32:0]       div_rem;

  logic              round_up;
  logic [DVD_W:0]    mag_rounded;
  logic              sat;
  logic [31:0]       mag32;
  fixed_t            t_res;
  logic              hit_res;

  assign pop       = !reset && (state == IDLE) && !num_empty && !den_empty;
  assign num_rd_en = pop;
  assign den_rd_en = pop;
  assign out_wr_en = !reset && (state == WRITE) && !out_full;

  assign num_mag      = fixed_abs(num);
  assign den_mag      = fixed_abs(den);
  assign div_start    = pop && (den != '0);
  assign div_dividend = DVD_W'(num_mag) << Q_BITS;

  udiv_seq #(
    .DIVIDEND_W(DVD_W),
    .DIVISOR_W (32)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (den_mag),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

`ifdef RAY_T_ROUND_EN
  assign round_up = ({div_rem, 1'b0} >= {2'b00, den_mag_q});
`else
  logic unused_round;
  assign round_up     = 1'b0;
  assign unused_round = ^{div_rem, den_mag_q};
`endif

  // Saturate the magnitude before applying the sign so the negative limit stays symmetric.
  always_comb begin
    mag_rounded = {1'b0, div_quo} + (DVD_W + 1)'(round_up);
    sat         = mag_rounded > (DVD_W + 1)'(32'h7FFF_FFFF);
    mag32       = sat ? 32'h7FFF_FFFF : mag_rounded[31:0];
    t_res       = sign_q ? -fixed_t'(mag32) : fixed_t'(mag32);
    hit_res     = !sat && !sign_q && (t_res >= fixed_t'(T_MIN));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_t     <= '0;
      out_hit   <= 1'b0;
      sign_q    <= 1'b0;
      den_mag_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sign_q    <= num[31] ^ den[31];
            den_mag_q <= den_mag;
            if (den == '0) begin
              out_t   <= num[31] ? T_SAT_NEG : T_SAT_POS;
              out_hit <= 1'b0;
              state   <= WRITE;
            end else begin
              state   <= DIV;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            out_t   <= t_res;
            out_hit <= hit_res;
            state   <= WRITE;
          end else if (!div_busy) begin
            state   <= IDLE;
          end
        end
        WRITE: begin
          if (!out_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_plane_t.sv
// Self-checking bench for ray_plane_t: directed vectors, corner-case sequences and
// randomized pairs checked against a plain-arithmetic reference model.
module tb_ray_plane_t;

  localparam int Q = 10;

  logic        clock;
  logic        reset;
  logic [31:0] num;
  logic        num_empty;
  logic        num_rd_en;
  logic [31:0] den;
  logic        den_empty;
  logic        den_rd_en;
  logic [31:0] out_t;
  logic        out_hit;
  logic        out_full;
  logic        out_wr_en;

  int tests_run;
  int tests_failed;

  ray_plane_t dut (
    .clock    (clock),
    .reset    (reset),
    .num      (num),
    .num_empty(num_empty),
    .num_rd_en(num_rd_en),
    .den      (den),
    .den_empty(den_empty),
    .den_rd_en(den_rd_en),
    .out_t    (out_t),
    .out_hit  (out_hit),
    .out_full (out_full),
    .out_wr_en(out_wr_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] t;
    logic        hit;
    int          lat;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: exact integer division of |num|*2^Q by |den|, then round/saturate/sign.
  function automatic void refModel(input logic [31:0] n, input logic [31:0] d,
                                   output logic [31:0] t, output logic h);
    longint sn, sd, an, ad, q, r, ts;
    bit sat, neg;
    sn = longint'(signed'(n));
    sd = longint'(signed'(d));
    if (sd == 0) begin
      t = (sn >= 0) ? 32'h7FFF_FFFF : 32'h8000_0001;
      h = 1'b0;
    end else begin
      an = (sn < 0) ? -sn : sn;
      ad = (sd < 0) ? -sd : sd;
      q  = (an * (longint'(1) << Q)) / ad;
      r  = (an * (longint'(1) << Q)) % ad;
`ifdef RAY_T_ROUND_EN
      if (2 * r >= ad) q = q + 1;
`else
      if (r < 0) q = 0;
`endif
      sat = (q > 64'h7FFF_FFFF);
      if (sat) q = 64'h7FFF_FFFF;
      neg = (sn < 0) != (sd < 0);
      ts  = neg ? -q : q;
      t   = ts[31:0];
      h   = !sat && !neg && (ts >= 1);
    end
  endfunction

  task automatic applyReset();
    reset     = 1'b1;
    num_empty = 1'b1;
    den_empty = 1'b1;
    out_full  = 1'b0;
    num       = '0;
    den       = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Presents a pair and returns once the pop cycle has been observed (at negedge+1 of cycle N).
  task automatic popPair(input logic [31:0] n, input logic [31:0] d, output bit ok);
    int k;
    @(negedge clock);
    num = n; den = d; num_empty = 1'b0; den_empty = 1'b0;
    #1;
    k = 0;
    while (!num_rd_en && k < 100) begin
      @(negedge clock); #1; k++;
    end
    ok = num_rd_en && den_rd_en;
  endtask

  // Counts cycles after the pop until out_wr_en, with a bounded wait.
  task automatic waitWrite(output int lat, output bit ok);
    @(negedge clock);
    num_empty = 1'b1; den_empty = 1'b1;
    #1;
    lat = 1;
    while (!out_wr_en && lat < 200) begin
      @(negedge clock); #1; lat++;
    end
    ok = out_wr_en;
  endtask

  task automatic applyStimulus(input logic [31:0] n, input logic [31:0] d,
                               output logic [31:0] t, output logic h, output int lat, output bit ok);
    bit ok1, ok2;
    popPair(n, d, ok1);
    if (!ok1) begin
      num_empty = 1'b1; den_empty = 1'b1;
      ok = 1'b0; lat = -1; t = 'x; h = 'x;
      return;
    end
    waitWrite(lat, ok2);
    ok = ok2; t = out_t; h = out_hit;
  endtask

  vec_t        vecs[$];
  logic [31:0] got_t, exp_t;
  logic        got_h, exp_h;
  int          lat, bad, wr_count, rd_count;
  bit          ok;

  initial begin
    tests_run = 0;
    tests_failed = 0;

    reset = 1'b1; out_full = 1'b0; num = 32'd7; den = 32'd9;
    num_empty = 1'b0; den_empty = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset_rd_en", {31'd0, num_rd_en | den_rd_en}, 32'd0);
    checkOutput("reset_wr_en", {31'd0, out_wr_en}, 32'd0);
    checkOutput("reset_out_t", out_t, 32'd0);
    checkOutput("reset_out_hit", {31'd0, out_hit}, 32'd0);
    applyReset();

    vecs.push_back('{32'd2048, 32'd1024, 32'd2048, 1'b1, 43});
    vecs.push_back('{-32'sd3072, 32'd1024, -32'sd3072, 1'b0, 43});
    vecs.push_back('{-32'sd2048, -32'sd1024, 32'd2048, 1'b1, 43});
    vecs.push_back('{32'd5, 32'd0, 32'h7FFF_FFFF, 1'b0, 1});
    vecs.push_back('{-32'sd5, 32'd0, 32'h8000_0001, 1'b0, 1});
`ifdef RAY_T_ROUND_EN
    vecs.push_back('{32'd2, 32'd3, 32'd683, 1'b1, 43});
`else
    vecs.push_back('{32'd2, 32'd3, 32'd682, 1'b1, 43});
`endif
    vecs.push_back('{32'h4000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 43});
    vecs.push_back('{32'd1, 32'd1024, 32'd1, 1'b1, 43});
    vecs.push_back('{32'd0, 32'd1024, 32'd0, 1'b0, 43});
    vecs.push_back('{32'h8000_0000, 32'd1024, 32'h8000_0001, 1'b0, 43});
    vecs.push_back('{-32'sd1, 32'd3, -32'sd341, 1'b0, 43});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].n, vecs[i].d, got_t, got_h, lat, ok);
      checkOutput($sformatf("vec%0d_done", i), {31'd0, ok}, 32'd1);
      checkOutput($sformatf("vec%0d_t", i), got_t, vecs[i].t);
      checkOutput($sformatf("vec%0d_hit", i), {31'd0, got_h}, {31'd0, vecs[i].hit});
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // One FIFO empty: no pop until both have data, then both pop together.
    @(negedge clock);
    num = 32'd4096; num_empty = 1'b0; den_empty = 1'b1;
    rd_count = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (num_rd_en || den_rd_en) rd_count++;
      @(negedge clock);
    end
    checkOutput("empty_den_no_pop", rd_count, 32'd0);
    den = 32'd2048; den_empty = 1'b0;
    #1;
    checkOutput("both_pop_together", {30'd0, num_rd_en, den_rd_en}, 32'd3);
    waitWrite(lat, ok);
    checkOutput("empty_den_t", out_t, 32'd2048);
    checkOutput("empty_den_latency", lat, 32'd43);

    // Output FIFO full: result held stable, exactly one write after release.
    out_full = 1'b1;
    popPair(32'd2048, 32'd1024, ok);
    @(negedge clock);
    num_empty = 1'b1; den_empty = 1'b1;
    repeat (42) @(negedge clock);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (out_wr_en || num_rd_en || out_t !== 32'd2048 || out_hit !== 1'b1) bad++;
      @(negedge clock);
    end
    checkOutput("full_hold_stable", bad, 32'd0);
    out_full = 1'b0;
    wr_count = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_wr_en) wr_count++;
      @(negedge clock);
    end
    checkOutput("full_single_write", wr_count, 32'd1);

    // Reset in the middle of a division abandons it.
    popPair(32'd5120, 32'd1024, ok);
    @(negedge clock);
    num_empty = 1'b1; den_empty = 1'b1;
    repeat (19) @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("midreset_out_t", out_t, 32'd0);
    checkOutput("midreset_flags", {29'd0, out_hit, out_wr_en, num_rd_en}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wr_count = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (out_wr_en) wr_count++;
      @(negedge clock);
    end
    checkOutput("midreset_no_write", wr_count, 32'd0);
    applyStimulus(32'd3072, 32'd1024, got_t, got_h, lat, ok);
    checkOutput("post_reset_t", got_t, 32'd3072);
    checkOutput("post_reset_hit", {31'd0, got_h}, 32'd1);

    // Randomized pairs across magnitude ranges, including zero divisors.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] rn, rd;
      case ($urandom_range(0, 2))
        0: rn = $urandom;
        1: rn = $urandom_range(0, 1 << 20);
        default: rn = -$urandom_range(0, 1 << 20);
      endcase
      case ($urandom_range(0, 5))
        0: rd = 32'd0;
        1, 2: rd = $urandom;
        3: rd = $urandom_range(1, 4096);
        default: rd = -$urandom_range(1, 1 << 16);
      endcase
      refModel(rn, rd, exp_t, exp_h);
      applyStimulus(rn, rd, got_t, got_h, lat, ok);
      checkOutput($sformatf("rand%0d_t n=%08h d=%08h", i, rn, rd), got_t, exp_t);
      checkOutput($sformatf("rand%0d_hit", i), {31'd0, got_h}, {31'd0, exp_h});
      checkOutput($sformatf("rand%0d_latency", i), lat, (rd == 32'd0) ? 32'd1 : 32'd43);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
